rom_download_router: RTL and testbench
======================================

Name: rom_download_router

Overview:
- Sits between hps_io's ioctl download stream and the williams2 core's ROM/RAM load port.
- Filters the stream by index and decodes each byte's address into a ROM region.
- Registers the byte and emits exactly one load strobe per accepted byte.
- Verifies the total image length and holds the core in reset until a complete, valid image has loaded and settled.

Parameters:
- ADDR_W, 18, width of the core load address (dn_addr).
- PROG_END, 18'h0C000, first address past the 6809 program ROM region (region 0).
- SND_END, 18'h0D000, first address past the sound CPU ROM region (region 1).
- TOTAL_BYTES, 18'h13000, first address past the graphics ROM region (region 2); also the required image length.
- SETTLE_CYCLES, 16, clk_sys cycles core_reset stays high after a good load.

Ports:
- clk_sys, input, 1, system clock (12 MHz domain).
- reset, input, 1, synchronous, active-high.
- ioctl_download, input, 1, download-in-progress level from hps_io.
- ioctl_wr, input, 1, byte-valid strobe from hps_io.
- ioctl_addr, input, 25, byte address.
- ioctl_dout, input, 8, byte data.
- ioctl_index, input, 16, download slot; only 0 is accepted.
- dn_addr, output, ADDR_W, registered load address to the core.
- dn_data, output, 8, registered load data.
- dn_wr, output, 1, one-cycle load strobe.
- dn_region, output, 2, region of current dn_addr: 0 prog, 1 sound, 2 gfx, 3 none.
- core_reset, output, 1, hold-in-reset for williams2; ORed with the global reset at top level.
- load_done, output, 1, image loaded and validated.
- load_error, output, 1, last download was invalid.
- byte_count, output, ADDR_W, accepted bytes in the current/last download (saturating).

Behaviour:
- Interface: one clock, clk_sys; reset is synchronous and active-high.
- Reset values: dn_addr 0, dn_data 0, dn_wr 0, dn_region 3, core_reset 1, load_done 0, load_error 0, byte_count 0, state IDLE, overflow flag 0.
- Write qualification:
  - Accept a byte on the rising edge of ioctl_wr (registered previous value) while ioctl_download=1 and ioctl_index=0.
  - A level held high for N cycles yields one strobe.
  - Strobes on consecutive cycles are impossible by the edge rule; strobes in alternate cycles must all be accepted.
- Address handling:
  - If ioctl_addr < TOTAL_BYTES, the byte is accepted.
  - Otherwise the byte is dropped (no dn_wr) and the overflow flag is set.
  - Upper ioctl_addr bits [24:ADDR_W] nonzero also count as out of range.
- Latency: dn_addr, dn_data, dn_region and dn_wr are all registered, one cycle after the qualifying edge. dn_addr and dn_data hold until the next accepted byte.
- Region decode:
  - addr < PROG_END → 0.
  - addr < SND_END → 1.
  - addr < TOTAL_BYTES → 2.
- byte_count:
  - Increments on each accepted byte and saturates at all-ones.
  - Cleared on entry to LOAD.
- State machine:
  - IDLE: core_reset=1. ioctl_download rises with index 0 → LOAD. Non-zero index is ignored.
  - LOAD: core_reset=1, load_done=0, load_error=0.
    - On ioctl_download falling: byte_count == TOTAL_BYTES and overflow=0 → SETTLE; otherwise → ERROR.
    - A byte strobed in the same cycle download falls is still accepted and counted before the check. The check uses the post-update count, via a one-cycle CHECK state.
  - CHECK: evaluates the count and overflow, then → SETTLE or ERROR.
  - SETTLE: core_reset=1; counts SETTLE_CYCLES, then → READY.
  - READY: core_reset=0, load_done=1. A new index-0 download → LOAD (core_reset reasserted the same cycle the state changes).
  - ERROR: core_reset=1, load_error=1. A new index-0 download → LOAD.
- Downloads with index ≠ 0 never change the state, outputs or count.
- Reset mid-operation returns to IDLE with all outputs at reset values; any partial load is discarded.

Decomposition:
- Package rom_download_pkg holds:
  - state enum {IDLE, LOAD, CHECK, SETTLE, READY, ERROR};
  - region constants REG_PROG=0, REG_SND=1, REG_GFX=2, REG_NONE=3;
  - default boundary constants.
- One natural sub-module, rom_region_decode: combinational address → region, parameterised by the boundaries. The FSM, counters and edge detect stay in the top module.

Test Plan:
- Good load:
  - Stimulus: index 0, addresses 0..0x12FFF, each as a 1-cycle ioctl_wr every 4 cycles, then download low.
  - Required: 0x13000 dn_wr pulses with matching addr/data; dn_region 0 up to 0xBFFF, 1 for 0xC000–0xCFFF, 2 above. load_done=1 and core_reset=0 exactly SETTLE_CYCLES+2 cycles after download falls.
- Short load:
  - Stimulus: addresses 0..0x12FFE only.
  - Required: load_error=1, load_done=0, core_reset stays 1, byte_count=0x12FFF.
- Overflow:
  - Stimulus: full image plus one byte at 0x13000.
  - Required: no dn_wr for 0x13000, load_error=1.
- Wrong index:
  - Stimulus: index 1 download of 16 bytes from READY.
  - Required: no dn_wr, state and outputs unchanged, core_reset stays 0.
- Held strobe:
  - Stimulus: ioctl_wr held high 5 cycles for one byte.
  - Required: exactly one dn_wr, one cycle after the rise.
- Reset mid-load:
  - Stimulus: assert reset after 100 bytes, then a full good load.
  - Required: all outputs return to reset values the cycle after reset. The second load ends load_done=1 with byte_count=0x13000.

Source files
------------

// File: rtl/rom_download_router_pkg.sv
// Shared types and default boundaries for the ROM download router.
// Region codes match the dn_region encoding seen by the core loader.
package rom_download_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    SETTLE,
    READY,
    ERROR
  } state_t;

  localparam logic [1:0] REG_PROG = 2'd0;
  localparam logic [1:0] REG_SND  = 2'd1;
  localparam logic [1:0] REG_GFX  = 2'd2;
  localparam logic [1:0] REG_NONE = 2'd3;

  localparam int          DEF_ADDR_W        = 18;
  localparam logic [17:0] DEF_PROG_END      = 18'h0C000;
  localparam logic [17:0] DEF_SND_END       = 18'h0D000;
  localparam logic [17:0] DEF_TOTAL_BYTES   = 18'h13000;
  localparam int          DEF_SETTLE_CYCLES = 16;

endpackage

// File: rtl/rom_download_router_if.sv
// ioctl download stream in, core load port out.
// master = stream source / loader sink, slave = the router.
interface rom_download_router_if #(
  parameter int ADDR_W = 18
);
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [15:0]       ioctl_index;
  logic [ADDR_W-1:0] dn_addr;
  logic [7:0]        dn_data;
  logic              dn_wr;
  logic [1:0]        dn_region;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  dn_addr, dn_data, dn_wr, dn_region
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output dn_addr, dn_data, dn_wr, dn_region
  );
endinterface

// File: rtl/rom_download_router_region_decode.sv
// Combinational load address to ROM region decode (prog / sound / gfx / none).
module rom_region_decode
  import rom_download_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] PROG_END    = DEF_PROG_END,
  parameter logic [ADDR_W-1:0] SND_END     = DEF_SND_END,
  parameter logic [ADDR_W-1:0] TOTAL_BYTES = DEF_TOTAL_BYTES
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [1:0]        region
);

  always_comb begin
    region = REG_NONE;
    if (addr < PROG_END)         region = REG_PROG;
    else if (addr < SND_END)     region = REG_SND;
    else if (addr < TOTAL_BYTES) region = REG_GFX;
  end

endmodule

// File: rtl/rom_download_router.sv
// Filters the ioctl stream to index 0, registers one load strobe per accepted byte,
// and holds the core in reset until a full-length image has loaded and settled.
module rom_download_router
  import rom_download_pkg::*;
#(
  parameter int                ADDR_W        = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] PROG_END      = DEF_PROG_END,
  parameter logic [ADDR_W-1:0] SND_END       = DEF_SND_END,
  parameter logic [ADDR_W-1:0] TOTAL_BYTES   = DEF_TOTAL_BYTES,
  parameter int                SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  rom_download_router_if.slave    bus,
  output logic                    core_reset,
  output logic                    load_done,
  output logic                    load_error,
  output logic [ADDR_W-1:0]       byte_count
);

  localparam int SW = $clog2(SETTLE_CYCLES) + 1;

  state_t          state, next_state;
  logic            wr_prev, dl_prev, overflow, load_entry;
  logic [SW-1:0]   settle_cnt;
  logic [1:0]      dec_region;
  logic            idx_ok, wr_edge, in_range, accept, drop, dl_rise, dl_fall;

  assign idx_ok   = (bus.ioctl_index == 16'd0);
  // dl_prev keeps a byte strobed in the very cycle download drops.
  assign wr_edge  = bus.ioctl_wr & ~wr_prev & (bus.ioctl_download | dl_prev) & idx_ok;
  assign in_range = (bus.ioctl_addr < 25'(TOTAL_BYTES));
  assign accept   = wr_edge & in_range;
  assign drop     = wr_edge & ~in_range;
  assign dl_rise  = bus.ioctl_download & ~dl_prev & idx_ok;
  assign dl_fall  = ~bus.ioctl_download & dl_prev;

  rom_region_decode #(
    .ADDR_W      (ADDR_W),
    .PROG_END    (PROG_END),
    .SND_END     (SND_END),
    .TOTAL_BYTES (TOTAL_BYTES)
  ) u_decode (
    .addr   (bus.ioctl_addr[ADDR_W-1:0]),
    .region (dec_region)
  );

  always_comb begin
    next_state = state;
    load_entry = 1'b0;
    case (state)
      IDLE, READY, ERROR: begin
        if (dl_rise) begin
          next_state = LOAD;
          load_entry = 1'b1;
        end
      end
      LOAD:    if (dl_fall) next_state = CHECK;
      CHECK:   next_state = (byte_count == TOTAL_BYTES && !overflow) ? SETTLE : ERROR;
      SETTLE:  if (settle_cnt == SW'(SETTLE_CYCLES - 1)) next_state = READY;
      default: next_state = IDLE;
    endcase
  end

  assign core_reset = (state != READY);
  assign load_done  = (state == READY);
  assign load_error = (state == ERROR);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state         <= IDLE;
      wr_prev       <= 1'b0;
      dl_prev       <= 1'b0;
      overflow      <= 1'b0;
      settle_cnt    <= '0;
      byte_count    <= '0;
      bus.dn_addr   <= '0;
      bus.dn_data   <= '0;
      bus.dn_wr     <= 1'b0;
      bus.dn_region <= REG_NONE;
    end else begin
      state      <= next_state;
      wr_prev    <= bus.ioctl_wr;
      dl_prev    <= bus.ioctl_download;
      bus.dn_wr  <= accept;
      settle_cnt <= (state == SETTLE) ? settle_cnt + SW'(1) : '0;
      if (accept) begin
        bus.dn_addr   <= bus.ioctl_addr[ADDR_W-1:0];
        bus.dn_data   <= bus.ioctl_dout;
        bus.dn_region <= dec_region;
      end
      if (load_entry) begin
        byte_count <= accept ? ADDR_W'(1) : '0;
        overflow   <= drop;
      end else begin
        if (accept && byte_count != '1) byte_count <= byte_count + ADDR_W'(1);
        if (drop) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rom_download_router.sv
// Randomised download stream against a queue-based model of load strobes and load status.
// Image boundaries are scaled down so several full loads fit in a short run.
module tb_rom_download_router;

  localparam logic [17:0] P_PROG  = 18'h000C0;
  localparam logic [17:0] P_SND   = 18'h000D0;
  localparam logic [17:0] P_TOTAL = 18'h00130;
  localparam int          P_SET   = 16;
  localparam int          INF     = 32'h7fffffff;

  typedef struct {
    logic [17:0] addr;
    logic [7:0]  data;
    logic [1:0]  rgn;
    int          cyc;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        core_reset, load_done, load_error;
  logic [17:0] byte_count;

  rom_download_router_if #(.ADDR_W(18)) bus ();

  rom_download_router #(
    .ADDR_W(18), .PROG_END(P_PROG), .SND_END(P_SND),
    .TOTAL_BYTES(P_TOTAL), .SETTLE_CYCLES(P_SET)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .bus        (bus),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_error (load_error),
    .byte_count (byte_count)
  );

  initial forever #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Model state. Status codes: 0 held in reset, 1 ready, 2 error.
  exp_t        q[$];
  logic        chk_en = 1'b0;
  int          m_prev = 0, m_final = 0, m_load_at = INF, m_final_at = INF;
  int          m_sent = 0;
  logic        m_ovf = 1'b0;
  logic [17:0] m_last_addr = '0, m_count = '0;
  logic [7:0]  m_last_data = '0;
  logic [1:0]  m_last_rgn = 2'd3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [1:0] ref_region(input logic [24:0] a);
    if (a < 25'(P_PROG))  return 2'd0;
    if (a < 25'(P_SND))   return 2'd1;
    if (a < 25'(P_TOTAL)) return 2'd2;
    return 2'd3;
  endfunction

  function automatic int status_at(input int t);
    if (t >= m_final_at) return m_final;
    if (t >= m_load_at)  return 0;
    return m_prev;
  endfunction

  always @(negedge clk_sys) begin
    if (chk_en) begin
      int   st;
      exp_t e;
      if (cyc == m_load_at) m_count = '0;
      if (bus.dn_wr) begin
        if (q.size() == 0) begin
          check("unexpected_dn_wr", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("dn_wr_cycle", e.cyc, cyc);
          m_last_addr = e.addr;
          m_last_data = e.data;
          m_last_rgn  = e.rgn;
          if (m_count != '1) m_count = m_count + 18'd1;
        end
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        check("missing_dn_wr", q[0].addr, 32'hFFFFFFFF);
        void'(q.pop_front());
      end
      check("dn_addr", bus.dn_addr, m_last_addr);
      check("dn_data", bus.dn_data, m_last_data);
      check("dn_region", bus.dn_region, m_last_rgn);
      check("byte_count", byte_count, m_count);
      st = status_at(cyc);
      check("core_reset", core_reset, (st != 1));
      check("load_done", load_done, (st == 1));
      check("load_error", load_error, (st == 2));
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic note_byte(input logic [24:0] a, input logic [7:0] d);
    exp_t e;
    if (bus.ioctl_index == 16'd0) begin
      if (a < 25'(P_TOTAL)) begin
        e.addr = a[17:0];
        e.data = d;
        e.rgn  = ref_region(a);
        e.cyc  = cyc + 1;
        q.push_back(e);
        m_sent++;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int hold, input int gap);
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    bus.ioctl_wr   = 1'b1;
    note_byte(a, d);
    repeat (hold) tick();
    bus.ioctl_wr = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic start_dl(input logic [15:0] idx);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    if (idx == 16'd0) begin
      m_prev     = status_at(cyc);
      m_load_at  = cyc + 1;
      m_final_at = INF;
      m_sent     = 0;
      m_ovf      = 1'b0;
    end
    repeat (2) tick();
  endtask

  // Leaves the caller at the cycle download was driven low.
  task automatic end_dl();
    bus.ioctl_download = 1'b0;
    if (bus.ioctl_index == 16'd0) begin
      if (m_sent == int'(P_TOTAL) && !m_ovf) begin
        m_final    = 1;
        m_final_at = cyc + P_SET + 2;
      end else begin
        m_final    = 2;
        m_final_at = cyc + 2;
      end
    end
  endtask

  task automatic expect_ready_timing();
    tick();
    bus.ioctl_wr = 1'b0;
    repeat (P_SET) tick();
    check("done_not_early", load_done, 1'b0);
    tick();
    check("done_on_time", load_done, 1'b1);
    check("core_reset_released", core_reset, 1'b0);
    check("good_count", byte_count, 18'h00130);
  endtask

  task automatic send_range(input int first, input int last, input int gap_max);
    for (int a = first; a <= last; a++)
      send_byte(25'(a), 8'($urandom), 1, $urandom_range(gap_max, 1));
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr = 1'b0;
    tick();
    check("rst_dn_addr", bus.dn_addr, 18'h0);
    check("rst_dn_data", bus.dn_data, 8'h0);
    check("rst_dn_wr", bus.dn_wr, 1'b0);
    check("rst_dn_region", bus.dn_region, 2'd3);
    check("rst_core_reset", core_reset, 1'b1);
    check("rst_load_done", load_done, 1'b0);
    check("rst_load_error", load_error, 1'b0);
    check("rst_byte_count", byte_count, 18'h0);
    reset = 1'b0;
    q.delete();
    m_prev = 0; m_load_at = INF; m_final_at = INF; m_sent = 0; m_ovf = 1'b0;
    m_last_addr = '0; m_last_data = '0; m_last_rgn = 2'd3; m_count = '0;
    chk_en = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.ioctl_index    = '0;
    repeat (2) tick();
    do_reset();

    // Good load, gaps 1..3 idle cycles (alternate-cycle strobes included).
    start_dl(16'd0);
    send_range(0, int'(P_TOTAL) - 1, 3);
    end_dl();
    expect_ready_timing();
    check("last_addr", bus.dn_addr, 18'h0012F);
    check("last_region", bus.dn_region, 2'd2);

    // Index 1 download while READY must be invisible.
    start_dl(16'd1);
    for (int i = 0; i < 16; i++) send_byte(25'(i), 8'($urandom), 1, 1);
    end_dl();
    repeat (20) tick();
    check("wrong_idx_core_reset", core_reset, 1'b0);
    check("wrong_idx_done", load_done, 1'b1);
    check("wrong_idx_count", byte_count, 18'h00130);

    // Held strobe on the first byte, then a load one byte short.
    start_dl(16'd0);
    send_byte(25'd0, 8'hA5, 5, 2);
    check("held_strobe_data", bus.dn_data, 8'hA5);
    send_range(1, int'(P_TOTAL) - 2, 2);
    end_dl();
    repeat (4) tick();
    check("short_error", load_error, 1'b1);
    check("short_done", load_done, 1'b0);
    check("short_core_reset", core_reset, 1'b1);
    check("short_count", byte_count, 18'h0012F);

    // Full image plus out-of-range bytes, including high address bits.
    start_dl(16'd0);
    send_range(0, int'(P_TOTAL) - 1, 3);
    send_byte(25'(P_TOTAL), 8'h5A, 1, 2);
    send_byte(25'h1000005, 8'h3C, 1, 2);
    check("ovf_dn_addr_held", bus.dn_addr, 18'h0012F);
    end_dl();
    repeat (4) tick();
    check("ovf_error", load_error, 1'b1);
    check("ovf_count", byte_count, 18'h00130);

    // Reset mid-load, then a good load whose last byte lands as download drops.
    start_dl(16'd0);
    send_range(0, 99, 3);
    do_reset();
    start_dl(16'd0);
    send_range(0, int'(P_TOTAL) - 2, 3);
    bus.ioctl_addr = 25'(P_TOTAL) - 25'd1;
    bus.ioctl_dout = 8'hC3;
    bus.ioctl_wr   = 1'b1;
    note_byte(25'(P_TOTAL) - 25'd1, 8'hC3);
    end_dl();
    expect_ready_timing();
    check("final_data", bus.dn_data, 8'hC3);

    repeat (5) tick();
    check("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
